// File: rtl/e1_rx_buf_arb.sv
// e1_rx_buf_arb: merges two E1 receive byte streams into one shared buffer
// write port. Each receiver owns a single-entry holding slot; a round-robin
// arbiter moves held entries into one output register that presents the
// memory write and stalls on mem_rdy.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rxN_data/ts/frame/mf  received byte and its location (N = 0, 1)
//   rxN_we, rxN_rdy    write request / holding slot free
//   mem_addr/data/we   buffer write, address {chan, mf, frame, ts}
//   mem_rdy            memory accepts the write this cycle
//   stat_ovfN          saturating count of writes dropped on a full slot
//   stat_clr           clears both drop counters
module e1_rx_buf_arb #(
  parameter int unsigned MFW = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rx0_data,
  input  logic [4:0]     rx0_ts,
  input  logic [3:0]     rx0_frame,
  input  logic [MFW-1:0] rx0_mf,
  input  logic           rx0_we,
  output logic           rx0_rdy,
  input  logic [7:0]     rx1_data,
  input  logic [4:0]     rx1_ts,
  input  logic [3:0]     rx1_frame,
  input  logic [MFW-1:0] rx1_mf,
  input  logic           rx1_we,
  output logic           rx1_rdy,
  output logic [MFW+9:0] mem_addr,
  output logic [7:0]     mem_data,
  output logic           mem_we,
  input  logic           mem_rdy,
  output logic [7:0]     stat_ovf0,
  output logic [7:0]     stat_ovf1,
  input  logic           stat_clr
);

  // holding entry layout: {mf, frame, ts, data}
  localparam int unsigned EW = MFW + 17;
  localparam int unsigned AW = MFW + 10;
  localparam logic [7:0]  CNT_MAX = 8'hFF;

  logic [1:0]          we;
  logic [1:0][EW-1:0]  rx_ent;
  logic [1:0]          hv;
  logic [1:0][EW-1:0]  hold;
  logic [1:0][7:0]     ovf;
  logic                lg;
  logic                ov;
  logic [AW-1:0]       out_addr;
  logic [7:0]          out_data;
  logic                load;
  logic                any_hv;
  logic                gnt;

  assign we        = {rx1_we, rx0_we};
  assign rx_ent[0] = {rx0_mf, rx0_frame, rx0_ts, rx0_data};
  assign rx_ent[1] = {rx1_mf, rx1_frame, rx1_ts, rx1_data};

  assign rx0_rdy   = ~hv[0];
  assign rx1_rdy   = ~hv[1];

  // Output register may take a new entry when empty or being drained.
  assign load   = ~ov | mem_rdy;
  assign any_hv = |hv;
  // Contention goes to the channel that did not win last time.
  assign gnt    = (&hv) ? ~lg : hv[1];

  // Control state: slot valids, output valid, last grant, drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hv  <= '0;
      ov  <= 1'b0;
      lg  <= 1'b1;
      ovf <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        // A full slot cannot be granted and captured in the same cycle,
        // which keeps each channel at one write per two cycles.
        if (we[n] && !hv[n]) begin
          hv[n] <= 1'b1;
        end else if (load && any_hv && (gnt == 1'(n))) begin
          hv[n] <= 1'b0;
        end

        if (stat_clr) begin
          ovf[n] <= '0;
        end else if (we[n] && hv[n] && (ovf[n] != CNT_MAX)) begin
          ovf[n] <= ovf[n] + 8'd1;
        end
      end

      if (load) begin
        ov <= any_hv;
        if (any_hv) begin
          lg <= gnt;
        end
      end
    end
  end

  // Datapath registers; contents only matter while the matching valid is set.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (we[n] && !hv[n]) begin
        hold[n] <= rx_ent[n];
      end
    end
    if (load && any_hv) begin
      out_addr <= {gnt, hold[gnt][EW-1:8]};
      out_data <= hold[gnt][7:0];
    end
  end

  assign mem_addr  = out_addr;
  assign mem_data  = out_data;
  assign mem_we    = ov;
  assign stat_ovf0 = ovf[0];
  assign stat_ovf1 = ovf[1];

endmodule

// File: tb/tb_e1_rx_buf_arb.sv
// Self-checking bench for e1_rx_buf_arb: directed scenarios plus a random
// run compared against a queue-based reference model.
module tb_e1_rx_buf_arb;

  localparam int unsigned MFW = 7;
  localparam int unsigned AW  = MFW + 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     rx0_data = '0, rx1_data = '0;
  logic [4:0]     rx0_ts = '0, rx1_ts = '0;
  logic [3:0]     rx0_frame = '0, rx1_frame = '0;
  logic [MFW-1:0] rx0_mf = '0, rx1_mf = '0;
  logic           rx0_we = 1'b0, rx1_we = 1'b0;
  logic           rx0_rdy, rx1_rdy;
  logic [AW-1:0]  mem_addr;
  logic [7:0]     mem_data;
  logic           mem_we;
  logic           mem_rdy = 1'b1;
  logic [7:0]     stat_ovf0, stat_ovf1;
  logic           stat_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  e1_rx_buf_arb #(.MFW(MFW)) dut (
    .clk(clk), .rst(rst),
    .rx0_data(rx0_data), .rx0_ts(rx0_ts), .rx0_frame(rx0_frame), .rx0_mf(rx0_mf),
    .rx0_we(rx0_we), .rx0_rdy(rx0_rdy),
    .rx1_data(rx1_data), .rx1_ts(rx1_ts), .rx1_frame(rx1_frame), .rx1_mf(rx1_mf),
    .rx1_we(rx1_we), .rx1_rdy(rx1_rdy),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_rdy(mem_rdy),
    .stat_ovf0(stat_ovf0), .stat_ovf1(stat_ovf1), .stat_clr(stat_clr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic           ch;
    logic [MFW-1:0] mf;
    logic [3:0]     fr;
    logic [4:0]     ts;
    logic [7:0]     d;
  } ent_t;

  ent_t m_slot0[$];
  ent_t m_slot1[$];
  ent_t m_out[$];
  int   m_last;
  int   m_cnt0, m_cnt1;

  always @(posedge clk) begin : model
    bit   ld, acc0, acc1, drp0, drp1;
    int   g;
    ent_t e;
    if (rst) begin
      m_slot0.delete(); m_slot1.delete(); m_out.delete();
      m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      acc0 = rx0_we && (m_slot0.size() == 0);
      drp0 = rx0_we && (m_slot0.size() != 0);
      acc1 = rx1_we && (m_slot1.size() == 0);
      drp1 = rx1_we && (m_slot1.size() != 0);
      ld   = (m_out.size() == 0) || mem_rdy;
      if (ld) begin
        m_out.delete();
        if (m_slot0.size() != 0 || m_slot1.size() != 0) begin
          if (m_slot0.size() != 0 && m_slot1.size() != 0) g = 1 - m_last;
          else g = (m_slot0.size() != 0) ? 0 : 1;
          e = (g == 0) ? m_slot0.pop_front() : m_slot1.pop_front();
          m_out.push_back(e);
          m_last = g;
        end
      end
      if (acc0) begin
        e.ch = 1'b0; e.mf = rx0_mf; e.fr = rx0_frame; e.ts = rx0_ts; e.d = rx0_data;
        m_slot0.push_back(e);
      end
      if (acc1) begin
        e.ch = 1'b1; e.mf = rx1_mf; e.fr = rx1_frame; e.ts = rx1_ts; e.d = rx1_data;
        m_slot1.push_back(e);
      end
      if (stat_clr) begin
        m_cnt0 = 0; m_cnt1 = 0;
      end else begin
        if (drp0 && m_cnt0 < 255) m_cnt0++;
        if (drp1 && m_cnt1 < 255) m_cnt1++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    rx0_we = 1'b0; rx1_we = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; rx0_we = 1'b1; rx1_we = 1'b1; mem_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %0b exp 0", mem_we); end
    vectors++; if (rx0_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_rx0_rdy: got %0b exp 1", rx0_rdy); end
    vectors++; if (rx1_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_rx1_rdy: got %0b exp 1", rx1_rdy); end
    vectors++; if (stat_ovf0 !== 8'd0) begin miscompares++; $display("FAIL rst_ovf0: got %0d exp 0", stat_ovf0); end
    vectors++; if (stat_ovf1 !== 8'd0) begin miscompares++; $display("FAIL rst_ovf1: got %0d exp 0", stat_ovf1); end
    rst = 1'b0; idle_inputs(); mem_rdy = 1'b1;
  endtask

  task automatic test_single_write();
    logic [AW-1:0] exp_a;
    exp_a = {1'b0, MFW'(5), 4'd3, 5'd17};
    do_reset();
    mem_rdy = 1'b1;
    rx0_we = 1'b1; rx0_mf = MFW'(5); rx0_frame = 4'd3; rx0_ts = 5'd17; rx0_data = 8'hA5;
    @(negedge clk);
    rx0_we = 1'b0;
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL sw_early_we: got %0b exp 0", mem_we); end
    vectors++; if (rx0_rdy !== 1'b0) begin miscompares++; $display("FAIL sw_rdy_busy: got %0b exp 0", rx0_rdy); end
    @(negedge clk);
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL sw_we: got %0b exp 1", mem_we); end
    vectors++; if (mem_addr !== exp_a) begin miscompares++; $display("FAIL sw_addr: got %h exp %h", mem_addr, exp_a); end
    vectors++; if (mem_data !== 8'hA5) begin miscompares++; $display("FAIL sw_data: got %h exp a5", mem_data); end
    vectors++; if (rx0_rdy !== 1'b1) begin miscompares++; $display("FAIL sw_rdy_free: got %0b exp 1", rx0_rdy); end
    @(negedge clk);
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL sw_we_clear: got %0b exp 0", mem_we); end
  endtask

  task automatic test_simultaneous();
    logic [AW-1:0] a0, a1;
    a0 = {1'b0, MFW'(10), 4'd2, 5'd4};
    a1 = {1'b1, MFW'(11), 4'd6, 5'd30};
    do_reset();
    mem_rdy = 1'b1;
    rx0_we = 1'b1; rx0_mf = MFW'(10); rx0_frame = 4'd2; rx0_ts = 5'd4;  rx0_data = 8'h3C;
    rx1_we = 1'b1; rx1_mf = MFW'(11); rx1_frame = 4'd6; rx1_ts = 5'd30; rx1_data = 8'hC3;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    vectors++; if (mem_we !== 1'b1 || mem_addr !== a0 || mem_data !== 8'h3C) begin
      miscompares++; $display("FAIL sim_first: got we=%0b addr=%h data=%h exp we=1 addr=%h data=3c", mem_we, mem_addr, mem_data, a0); end
    vectors++; if (rx1_rdy !== 1'b0) begin miscompares++; $display("FAIL sim_rx1_wait: got %0b exp 0", rx1_rdy); end
    @(negedge clk);
    vectors++; if (mem_we !== 1'b1 || mem_addr !== a1 || mem_data !== 8'hC3) begin
      miscompares++; $display("FAIL sim_second: got we=%0b addr=%h data=%h exp we=1 addr=%h data=c3", mem_we, mem_addr, mem_data, a1); end
    @(negedge clk);
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL sim_drain: got %0b exp 0", mem_we); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a0, a1, a2;
    a0 = {1'b0, MFW'(1), 4'd1, 5'd1};
    a1 = {1'b1, MFW'(2), 4'd2, 5'd2};
    a2 = {1'b0, MFW'(3), 4'd3, 5'd3};
    do_reset();
    mem_rdy = 1'b0;
    rx0_we = 1'b1; rx0_mf = MFW'(1); rx0_frame = 4'd1; rx0_ts = 5'd1; rx0_data = 8'h11;
    rx1_we = 1'b1; rx1_mf = MFW'(2); rx1_frame = 4'd2; rx1_ts = 5'd2; rx1_data = 8'h22;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rx0_we = 1'b1; rx0_mf = MFW'(3); rx0_frame = 4'd3; rx0_ts = 5'd3; rx0_data = 8'h33;
    @(negedge clk);
    rx0_we = 1'b0; rx0_data = 8'h44;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (mem_we !== 1'b1 || mem_addr !== a0 || mem_data !== 8'h11) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got we=%0b addr=%h data=%h exp we=1 addr=%h data=11", i, mem_we, mem_addr, mem_data, a0); end
      vectors++; if (rx0_rdy !== 1'b0 || rx1_rdy !== 1'b0) begin
        miscompares++; $display("FAIL bp_rdy[%0d]: got %0b%0b exp 00", i, rx1_rdy, rx0_rdy); end
      rx0_we = (i == 1);
      @(negedge clk);
    end
    rx0_we = 1'b0;
    vectors++; if (stat_ovf0 !== 8'd1) begin miscompares++; $display("FAIL bp_ovf0: got %0d exp 1", stat_ovf0); end
    mem_rdy = 1'b1;
    @(negedge clk);
    vectors++; if (mem_we !== 1'b1 || mem_addr !== a1 || mem_data !== 8'h22) begin
      miscompares++; $display("FAIL bp_out1: got we=%0b addr=%h data=%h exp we=1 addr=%h data=22", mem_we, mem_addr, mem_data, a1); end
    @(negedge clk);
    vectors++; if (mem_we !== 1'b1 || mem_addr !== a2 || mem_data !== 8'h33) begin
      miscompares++; $display("FAIL bp_out2: got we=%0b addr=%h data=%h exp we=1 addr=%h data=33", mem_we, mem_addr, mem_data, a2); end
    @(negedge clk);
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %0b exp 0", mem_we); end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_rdy = 1'b0;
    rx1_we = 1'b1; rx1_data = 8'h5A;
    // first two requests are absorbed by the output register and the slot
    for (int i = 0; i < 10; i++) @(negedge clk);
    vectors++; if (stat_ovf1 !== 8'd8) begin miscompares++; $display("FAIL sat_mid: got %0d exp 8", stat_ovf1); end
    for (int i = 0; i < 300; i++) @(negedge clk);
    vectors++; if (stat_ovf1 !== 8'd255) begin miscompares++; $display("FAIL sat_max: got %0d exp 255", stat_ovf1); end
    vectors++; if (stat_ovf0 !== 8'd0) begin miscompares++; $display("FAIL sat_ovf0: got %0d exp 0", stat_ovf0); end
    stat_clr = 1'b1;
    @(negedge clk);
    vectors++; if (stat_ovf1 !== 8'd0) begin miscompares++; $display("FAIL sat_clr: got %0d exp 0", stat_ovf1); end
    stat_clr = 1'b0;
    @(negedge clk);
    vectors++; if (stat_ovf1 !== 8'd1) begin miscompares++; $display("FAIL sat_recount: got %0d exp 1", stat_ovf1); end
    rx1_we = 1'b0; mem_rdy = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
  endtask

  task automatic test_fairness();
    int   writes, seq0, seq1, exp0, exp1;
    logic prev_ch;
    bit   have_prev;
    writes = 0; seq0 = 0; seq1 = 0; exp0 = 0; exp1 = 0; have_prev = 0; prev_ch = 1'b0;
    do_reset();
    mem_rdy = 1'b1;
    rx0_mf = MFW'(7); rx0_frame = 4'd1; rx0_ts = 5'd0;
    rx1_mf = MFW'(9); rx1_frame = 4'd2; rx1_ts = 5'd1;
    for (int i = 0; i < 40; i++) begin
      if (mem_we === 1'b1) begin
        writes++;
        if (have_prev) begin
          vectors++; if (mem_addr[AW-1] === prev_ch) begin
            miscompares++; $display("FAIL fair_alt[%0d]: got chan %0b exp %0b", i, mem_addr[AW-1], ~prev_ch); end
        end
        if (mem_addr[AW-1] === 1'b0) begin
          vectors++; if (mem_data !== 8'(exp0)) begin miscompares++; $display("FAIL fair_d0[%0d]: got %h exp %h", i, mem_data, 8'(exp0)); end
          exp0++;
        end else begin
          vectors++; if (mem_data !== 8'(8'h80 + exp1)) begin miscompares++; $display("FAIL fair_d1[%0d]: got %h exp %h", i, mem_data, 8'(8'h80 + exp1)); end
          exp1++;
        end
        prev_ch = mem_addr[AW-1]; have_prev = 1;
      end
      rx0_we = 1'b0; rx1_we = 1'b0;
      if (i < 38) begin
        if (rx0_rdy) begin rx0_we = 1'b1; rx0_data = 8'(seq0); seq0++; end
        if (rx1_rdy) begin rx1_we = 1'b1; rx1_data = 8'(8'h80 + seq1); seq1++; end
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk); @(negedge clk);
    vectors++; if (writes != 38) begin miscompares++; $display("FAIL fair_rate: got %0d writes exp 38", writes); end
    vectors++; if (stat_ovf0 !== 8'd0 || stat_ovf1 !== 8'd0) begin
      miscompares++; $display("FAIL fair_drops: got %0d/%0d exp 0/0", stat_ovf0, stat_ovf1); end
  endtask

  task automatic test_reset_stalled();
    do_reset();
    mem_rdy = 1'b0;
    rx0_we = 1'b1; rx0_data = 8'h77;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rx0_we = 1'b0;
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL rs_stalled: got %0b exp 1", mem_we); end
    vectors++; if (stat_ovf0 !== 8'd1) begin miscompares++; $display("FAIL rs_pre_ovf0: got %0d exp 1", stat_ovf0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rs_we: got %0b exp 0", mem_we); end
    vectors++; if (rx0_rdy !== 1'b1 || rx1_rdy !== 1'b1) begin miscompares++; $display("FAIL rs_rdy: got %0b%0b exp 11", rx1_rdy, rx0_rdy); end
    vectors++; if (stat_ovf0 !== 8'd0 || stat_ovf1 !== 8'd0) begin miscompares++; $display("FAIL rs_cnt: got %0d/%0d exp 0/0", stat_ovf0, stat_ovf1); end
    mem_rdy = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rs_dropped: got %0b exp 0", mem_we); end
  endtask

  task automatic test_random();
    logic [AW-1:0] ea;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      vectors++;
      if (mem_we !== (m_out.size() != 0)) begin
        miscompares++; $display("FAIL rnd_we[%0d]: got %0b exp %0b", i, mem_we, m_out.size() != 0);
      end else if (m_out.size() != 0) begin
        ea = {m_out[0].ch, m_out[0].mf, m_out[0].fr, m_out[0].ts};
        if (mem_addr !== ea || mem_data !== m_out[0].d) begin
          miscompares++; $display("FAIL rnd_wr[%0d]: got addr=%h data=%h exp addr=%h data=%h", i, mem_addr, mem_data, ea, m_out[0].d);
        end
      end
      vectors++;
      if (rx0_rdy !== (m_slot0.size() == 0) || rx1_rdy !== (m_slot1.size() == 0)) begin
        miscompares++; $display("FAIL rnd_rdy[%0d]: got %0b%0b exp %0b%0b", i, rx1_rdy, rx0_rdy, m_slot1.size() == 0, m_slot0.size() == 0);
      end
      vectors++;
      if (stat_ovf0 !== 8'(m_cnt0) || stat_ovf1 !== 8'(m_cnt1)) begin
        miscompares++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d exp %0d/%0d", i, stat_ovf0, stat_ovf1, m_cnt0, m_cnt1);
      end
      rx0_we    = ($urandom_range(0, 2) == 0);
      rx1_we    = ($urandom_range(0, 2) == 0);
      rx0_data  = 8'($urandom);  rx1_data  = 8'($urandom);
      rx0_ts    = 5'($urandom);  rx1_ts    = 5'($urandom);
      rx0_frame = 4'($urandom);  rx1_frame = 4'($urandom);
      rx0_mf    = MFW'($urandom); rx1_mf   = MFW'($urandom);
      mem_rdy   = ($urandom_range(0, 3) != 0);
      stat_clr  = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    idle_inputs(); mem_rdy = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_backpressure();
    test_saturation();
    test_fairness();
    test_reset_stalled();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
